// File: rtl/cmd_entry_ctrl_if.sv
// rtl/cmd_entry_ctrl_if.sv - keypad strobes and executor valid/ready bundle for cmd_entry_ctrl
interface cmd_entry_ctrl_if;
   logic        key_valid;
   logic [3:0]  key_data;
   logic        key_left;
   logic        key_right;
   logic        key_clear;
   logic        key_enter;
   logic        cmd_ready;
   logic [11:0] cmd_buf;
   logic        cmd_valid;

   modport master (
      output key_valid, key_data, key_left, key_right, key_clear, key_enter, cmd_ready,
      input  cmd_buf, cmd_valid
   );

   modport slave (
      input  key_valid, key_data, key_left, key_right, key_clear, key_enter, cmd_ready,
      output cmd_buf, cmd_valid
   );
endinterface

// File: rtl/cmd_entry_ctrl.sv
// rtl/cmd_entry_ctrl.sv - hex keypad command-word editor with executor handshake and cursor blink
// Optional CMD_ENTRY_AUTO_CLEAR_EN: zero the command buffer after each accepted transfer.
module cmd_entry_ctrl #(
   parameter int BLINK_W     = 23,
   parameter int ACK_TIMEOUT = 1000
) (
   input  logic              clk_i,
   input  logic              rst_i,
   cmd_entry_ctrl_if.slave   bus,
   output logic [1:0]        cursor_o,
   output logic [3:0]        blank_mask_o,
   output logic              busy_o,
   output logic              err_o
);
   localparam logic [1:0] ST_EDIT = 2'd0;
   localparam logic [1:0] ST_SEND = 2'd1;
   localparam logic [1:0] ST_ERR  = 2'd2;

   localparam int TO_W = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;
   localparam logic [TO_W-1:0] TO_LAST = TO_W'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);

   logic [1:0]         state_q, state_d;
   logic [11:0]        buf_q, buf_d;
   logic               valid_q, valid_d;
   logic [1:0]         cursor_q, cursor_d;
   logic [3:0]         blank_q, blank_d;
   logic               busy_q, err_q;
   logic [BLINK_W-1:0] blink_q, blink_d;
   logic [TO_W-1:0]    to_q, to_d;
   logic               xfer;
   logic               blink_on;

   assign xfer     = valid_q & bus.cmd_ready;
   assign blink_d  = blink_q + BLINK_W'(1);
   assign blink_on = blink_d[BLINK_W-1];

   always_comb begin
      state_d  = state_q;
      buf_d    = buf_q;
      valid_d  = valid_q;
      cursor_d = cursor_q;
      to_d     = to_q;
      case (state_q)
         ST_EDIT: begin
            if (bus.key_clear) begin
               buf_d    = '0;
               cursor_d = 2'd0;
            end else if (bus.key_enter) begin
               state_d = ST_SEND;
               valid_d = 1'b1;
               to_d    = '0;
            end else if (bus.key_valid) begin
               // Narrow fields keep only the low bits of the typed digit
               case (cursor_q)
                  2'd0:    buf_d[11]   = bus.key_data[0];
                  2'd1:    buf_d[10:7] = bus.key_data;
                  2'd2:    buf_d[6:4]  = bus.key_data[2:0];
                  default: buf_d[3:0]  = bus.key_data;
               endcase
               cursor_d = cursor_q + 2'd1;
            end else if (bus.key_right) begin
               cursor_d = cursor_q + 2'd1;
            end else if (bus.key_left) begin
               cursor_d = cursor_q - 2'd1;
            end
         end
         ST_SEND: begin
            if (xfer) begin
               state_d  = ST_EDIT;
               valid_d  = 1'b0;
               cursor_d = 2'd0;
`ifdef CMD_ENTRY_AUTO_CLEAR_EN
               buf_d    = '0;
`endif
            end else begin
               to_d = to_q + TO_W'(1);
               if (ACK_TIMEOUT != 0 && to_q == TO_LAST) begin
                  state_d = ST_ERR;
                  valid_d = 1'b0;
               end
            end
         end
         ST_ERR: begin
            if (bus.key_clear) begin
               state_d  = ST_EDIT;
               buf_d    = '0;
               cursor_d = 2'd0;
            end
         end
         default: state_d = ST_EDIT;
      endcase
   end

   // Mask is derived from next-cycle values so it lines up with the registered cursor and counter
   always_comb begin
      blank_d = 4'b0000;
      case (state_d)
         ST_EDIT: blank_d = blink_on ? (4'b0001 << cursor_d) : 4'b0000;
         ST_ERR:  blank_d = {4{blink_on}};
         default: blank_d = 4'b0000;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= ST_EDIT;
         buf_q    <= '0;
         valid_q  <= 1'b0;
         cursor_q <= 2'd0;
         blank_q  <= 4'b0000;
         busy_q   <= 1'b0;
         err_q    <= 1'b0;
         blink_q  <= '0;
         to_q     <= '0;
      end else begin
         state_q  <= state_d;
         buf_q    <= buf_d;
         valid_q  <= valid_d;
         cursor_q <= cursor_d;
         blank_q  <= blank_d;
         busy_q   <= (state_d != ST_EDIT);
         err_q    <= (state_d == ST_ERR);
         blink_q  <= blink_d;
         to_q     <= to_d;
      end
   end

   assign bus.cmd_buf   = buf_q;
   assign bus.cmd_valid = valid_q;
   assign cursor_o      = cursor_q;
   assign blank_mask_o  = blank_q;
   assign busy_o        = busy_q;
   assign err_o         = err_q;
endmodule

// File: tb/tb_cmd_entry_ctrl.sv
// tb/tb_cmd_entry_ctrl.sv - randomized and directed self-checking bench for cmd_entry_ctrl
module tb_cmd_entry_ctrl;
   localparam int BW = 4;
   localparam int TO = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   cmd_entry_ctrl_if bus();
   logic [1:0] cursor;
   logic [3:0] blank;
   logic       busy, err;

   cmd_entry_ctrl #(.BLINK_W(BW), .ACK_TIMEOUT(TO)) dut (
      .clk_i(clk), .rst_i(rst), .bus(bus),
      .cursor_o(cursor), .blank_mask_o(blank), .busy_o(busy), .err_o(err)
   );

   int n_chk = 0;
   int n_fail = 0;

   task automatic check(input string name, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: mode 0=edit 1=send 2=err, digits kept as separate hex fields
   int  m_mode, m_cur, m_tick, m_wait;
   int  m_dig[4];
   bit  m_valid;
   bit  chk_en = 1'b0;
   int  wmask[4] = '{1, 15, 7, 15};

   function automatic int m_buf();
      return m_dig[0] * 2048 + m_dig[1] * 128 + m_dig[2] * 16 + m_dig[3];
   endfunction

   function automatic int m_blank();
      bit b;
      b = (m_tick % (1 << BW)) >= (1 << (BW - 1));
      case (m_mode)
         0:       return b ? (1 << m_cur) : 0;
         2:       return b ? 15 : 0;
         default: return 0;
      endcase
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m_mode = 0; m_cur = 0; m_tick = 0; m_wait = 0; m_valid = 0;
         for (int i = 0; i < 4; i++) m_dig[i] = 0;
         chk_en = 1'b1;
      end else if (chk_en) begin
         m_tick++;
         case (m_mode)
            0: begin
               if (bus.key_clear) begin
                  for (int i = 0; i < 4; i++) m_dig[i] = 0;
                  m_cur = 0;
               end else if (bus.key_enter) begin
                  m_mode = 1; m_valid = 1; m_wait = 0;
               end else if (bus.key_valid) begin
                  m_dig[m_cur] = int'(bus.key_data) & wmask[m_cur];
                  m_cur = (m_cur + 1) % 4;
               end else if (bus.key_right) begin
                  m_cur = (m_cur + 1) % 4;
               end else if (bus.key_left) begin
                  m_cur = (m_cur + 3) % 4;
               end
            end
            1: begin
               if (bus.cmd_ready) begin
                  m_mode = 0; m_valid = 0; m_cur = 0;
`ifdef CMD_ENTRY_AUTO_CLEAR_EN
                  for (int i = 0; i < 4; i++) m_dig[i] = 0;
`endif
               end else begin
                  m_wait++;
                  if (m_wait == TO) begin
                     m_mode = 2; m_valid = 0;
                  end
               end
            end
            default: begin
               if (bus.key_clear) begin
                  m_mode = 0; m_cur = 0;
                  for (int i = 0; i < 4; i++) m_dig[i] = 0;
               end
            end
         endcase
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("cmd_buf",    int'(bus.cmd_buf),   m_buf());
         check("cmd_valid",  int'(bus.cmd_valid), int'(m_valid));
         check("cursor",     int'(cursor),        m_cur);
         check("blank_mask", int'(blank),         m_blank());
         check("busy",       int'(busy),          int'(m_mode != 0));
         check("err",        int'(err),           int'(m_mode == 2));
      end
   end

   int vcnt = 0;
   always @(negedge clk) if (bus.cmd_valid === 1'b1) vcnt++;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic digit(input logic [3:0] d);
      bus.key_valid = 1'b1; bus.key_data = d;
      step();
      bus.key_valid = 1'b0;
   endtask

   task automatic keys(input bit l, input bit r, input bit c, input bit e);
      bus.key_left = l; bus.key_right = r; bus.key_clear = c; bus.key_enter = e;
      step();
      bus.key_left = 0; bus.key_right = 0; bus.key_clear = 0; bus.key_enter = 0;
   endtask

   int exp_keep;
   int rdy_pct;
   int blink_k[4]   = '{7, 8, 15, 16};
   int blink_exp[4] = '{0, 2, 2, 0};

   initial begin
`ifdef CMD_ENTRY_AUTO_CLEAR_EN
      exp_keep = 0;
`else
      exp_keep = 12'hFDA;
`endif
      bus.key_valid = 0; bus.key_data = 0; bus.key_left = 0; bus.key_right = 0;
      bus.key_clear = 0; bus.key_enter = 0; bus.cmd_ready = 0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      @(negedge clk);
      check("reset cmd_buf", int'(bus.cmd_buf), 0);
      check("reset cmd_valid", int'(bus.cmd_valid), 0);
      check("reset blank", int'(blank), 0);

      digit(4'h1); digit(4'hF); digit(4'h5); digit(4'hA);
      @(negedge clk);
      check("entry FDA", int'(bus.cmd_buf), 12'hFDA);
      check("entry cursor wrap", int'(cursor), 0);

      keys(0, 1, 0, 0); keys(0, 1, 0, 0);
      digit(4'hF);
      @(negedge clk);
      check("cmd hi field F", int'(bus.cmd_buf), 12'hFFA);
      check("cursor after digit2", int'(cursor), 3);
      keys(0, 1, 0, 0);
      @(negedge clk);
      check("right wrap", int'(cursor), 0);
      keys(1, 0, 0, 0);
      @(negedge clk);
      check("left wrap", int'(cursor), 3);
      keys(1, 0, 0, 0);
      digit(4'h5);

      vcnt = 0;
      keys(0, 0, 0, 1);
      for (int i = 0; i < 5; i++) begin
         bus.key_valid = 1'b1; bus.key_data = 4'($urandom); bus.key_clear = (i == 2);
         step();
      end
      bus.key_valid = 0; bus.key_clear = 0;
      bus.cmd_ready = 1'b1;
      step();
      bus.cmd_ready = 1'b0;
      step(); step();
      @(negedge clk);
      check("send valid cycles", vcnt, 6);
      check("buf after transfer", int'(bus.cmd_buf), exp_keep);
      check("cursor after transfer", int'(cursor), 0);

      if (exp_keep == 0) begin
         keys(0, 0, 1, 0);
         digit(4'h1); digit(4'hF); digit(4'h5); digit(4'hA);
      end
      vcnt = 0;
      keys(0, 0, 0, 1);
      for (int i = 0; i < 7; i++) step();
      @(negedge clk);
      check("err not yet", int'(err), 0);
      step();
      @(negedge clk);
      check("timeout valid cycles", vcnt, 8);
      check("timeout err", int'(err), 1);
      check("timeout buf kept", int'(bus.cmd_buf), 12'hFDA);
      keys(0, 0, 0, 1);
      @(negedge clk);
      check("enter ignored in err", int'(err), 1);
      keys(0, 0, 1, 0);
      @(negedge clk);
      check("clear leaves err", int'(err), 0);
      check("clear zeroes buf", int'(bus.cmd_buf), 0);

      digit(4'h3);
      bus.key_clear = 1'b1; bus.key_valid = 1'b1; bus.key_data = 4'h7;
      step();
      bus.key_clear = 1'b0; bus.key_valid = 1'b0;
      @(negedge clk);
      check("clear beats digit buf", int'(bus.cmd_buf), 0);
      check("clear beats digit cursor", int'(cursor), 0);

      digit(4'h9);
      keys(0, 0, 0, 1);
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      @(negedge clk);
      check("rst mid-send valid", int'(bus.cmd_valid), 0);
      check("rst mid-send buf", int'(bus.cmd_buf), 0);
      check("rst mid-send busy", int'(busy), 0);

      keys(0, 1, 0, 0);
      for (int k = 2; k <= 16; k++) begin
         step();
         for (int j = 0; j < 4; j++)
            if (blink_k[j] == k) check("blink cursor1", int'(blank), blink_exp[j]);
      end

      rdy_pct = 30;
      for (int n = 0; n < 4000; n++) begin
         if (n % 200 == 0) rdy_pct = $urandom_range(5, 90);
         bus.key_valid = ($urandom_range(0, 99) < 20);
         bus.key_data  = 4'($urandom);
         bus.key_left  = ($urandom_range(0, 99) < 8);
         bus.key_right = ($urandom_range(0, 99) < 8);
         bus.key_clear = ($urandom_range(0, 99) < 4);
         bus.key_enter = ($urandom_range(0, 99) < 6);
         bus.cmd_ready = ($urandom_range(0, 99) < rdy_pct);
         rst           = ($urandom_range(0, 999) < 3);
         step();
      end
      bus.key_valid = 0; bus.key_left = 0; bus.key_right = 0;
      bus.key_clear = 0; bus.key_enter = 0; bus.cmd_ready = 0; rst = 0;
      step(); step();
      @(negedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
